// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the IF fetch controller.
package if_fetch_ctrl_pkg;

   localparam int unsigned FETCH_BUS_WD = 64;
   localparam int unsigned PC_W         = 32;
   localparam int unsigned INST_W       = 32;
   localparam int unsigned PERF_CNT_W   = 32;

   localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h1c00_0000;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_DATA = 3'd2,
      ST_HOLD = 3'd3,
      ST_DROP = 3'd4
   } fetch_state_e;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_bus_t;

endpackage

// File: rtl/if_fetch_ctrl_perf_cnt.sv
// Fetch / drop event counters, built only with IF_FETCH_PERF_CNT_EN.
module if_fetch_ctrl_perf_cnt
   import if_fetch_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fetch_inc_i,
   input  logic                  drop_inc_i,
   output logic [PERF_CNT_W-1:0] fetch_cnt_o,
   output logic [PERF_CNT_W-1:0] drop_cnt_o
);

   logic [PERF_CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
   logic [PERF_CNT_W-1:0] drop_cnt_q,  drop_cnt_d;

   // Free-running wrap-around increments.
   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      if (fetch_inc_i) fetch_cnt_d = fetch_cnt_q + PERF_CNT_W'(1);
      if (drop_inc_i)  drop_cnt_d  = drop_cnt_q + PERF_CNT_W'(1);
   end

   // Counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign fetch_cnt_o = fetch_cnt_q;
   assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch sequencer between IF PC generation and IPD.
// One outstanding addr_ok/data_ok request; buffers the returned instruction
// until IPD accepts it; discards killed fetches on redirect.
// Optional counters: define IF_FETCH_PERF_CNT_EN.
module if_fetch_ctrl
   import if_fetch_ctrl_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned     ADDR_W   = 32
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    fetch_req,
   input  logic [ADDR_W-1:0]       fetch_pc,
   output logic                    fetch_gnt,
   input  logic                    redirect,
   output logic                    inst_ram_req,
   output logic [ADDR_W-1:0]       inst_ram_addr,
   input  logic                    inst_ram_addr_ok,
   input  logic                    inst_ram_data_ok,
   input  logic [INST_W-1:0]       inst_ram_rdata,
   input  logic                    IPD_allow_in,
   output logic                    IF_to_IPD_valid,
   output logic [FETCH_BUS_WD-1:0] IF_to_IPD_bus,
   output logic [PERF_CNT_W-1:0]   perf_fetch_cnt,
   output logic [PERF_CNT_W-1:0]   perf_drop_cnt
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic              kill_q,  kill_d;
   logic              valid_q, valid_d;
   fetch_bus_t        bus_q,   bus_d;

   logic              issue_c;
   logic              req_c;
   logic [ADDR_W-1:0] ram_addr_c;

   // Next-state, RAM request and grant generation.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      kill_d     = kill_q;
      valid_d    = valid_q;
      bus_d      = bus_q;
      issue_c    = 1'b0;
      req_c      = 1'b0;
      ram_addr_c = addr_q;

      case (state_q)
         ST_IDLE: issue_c = fetch_req & ~redirect;
         ST_ADDR: begin
            // Request stays up until accepted, even if killed meanwhile.
            req_c = 1'b1;
            if (redirect) kill_d = 1'b1;
            if (inst_ram_addr_ok) state_d = (kill_q | redirect) ? ST_DROP : ST_DATA;
         end
         ST_DATA: begin
            if (inst_ram_data_ok) begin
               if (redirect) begin
                  state_d = ST_IDLE;
               end else begin
                  bus_d.pc   = PC_W'(addr_q);
                  bus_d.inst = inst_ram_rdata;
                  valid_d    = 1'b1;
                  state_d    = ST_HOLD;
               end
            end else if (redirect) begin
               kill_d  = 1'b1;
               state_d = ST_DROP;
            end
         end
         ST_HOLD: begin
            if (redirect) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
            end else if (IPD_allow_in) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
               issue_c = fetch_req;
            end
         end
         ST_DROP: begin
            if (inst_ram_data_ok) begin
               kill_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // New request from IDLE or from HOLD as the buffer drains.
      if (issue_c) begin
         req_c      = 1'b1;
         ram_addr_c = fetch_pc;
         addr_d     = fetch_pc;
         state_d    = inst_ram_addr_ok ? ST_DATA : ST_ADDR;
      end

      if (reset) req_c = 1'b0;
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= ADDR_W'(RESET_PC);
         kill_q     <= 1'b0;
         valid_q    <= 1'b0;
         bus_q.pc   <= RESET_PC;
         bus_q.inst <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         kill_q  <= kill_d;
         valid_q <= valid_d;
         bus_q   <= bus_d;
      end
   end

   assign inst_ram_req    = req_c;
   assign inst_ram_addr   = ram_addr_c;
   assign fetch_gnt       = req_c & inst_ram_addr_ok & ~kill_q & ~redirect;
   assign IF_to_IPD_valid = valid_q;
   assign IF_to_IPD_bus   = bus_q;

`ifdef IF_FETCH_PERF_CNT_EN
   logic fetch_inc_c;
   logic drop_inc_c;

   assign fetch_inc_c = (state_q == ST_DATA) & inst_ram_data_ok & ~redirect;
   assign drop_inc_c  = inst_ram_data_ok &
                        (((state_q == ST_DATA) & redirect) | (state_q == ST_DROP));

   if_fetch_ctrl_perf_cnt u_perf_cnt (
      .clk         (clk),
      .reset       (reset),
      .fetch_inc_i (fetch_inc_c),
      .drop_inc_i  (drop_inc_c),
      .fetch_cnt_o (perf_fetch_cnt),
      .drop_cnt_o  (perf_drop_cnt)
   );
`else
   assign perf_fetch_cnt = '0;
   assign perf_drop_cnt  = '0;
`endif

endmodule
